// File: rtl/mult16_share_pkg.sv
// rtl/mult16_share_pkg.sv - shared types and widths for the multiplier sharing controller
package mult16_share_pkg;

   localparam int W    = 16;
   localparam int PW   = 32;
   localparam int ID_W = 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/booth4_wallace_mult16.sv
// rtl/booth4_wallace_mult16.sv - combinational radix-4 Booth 16x16 signed multiplier with carry-save reduction
module booth4_wallace_mult16 (
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic [31:0] p
);

   logic [16:0] b_ext;
   logic [31:0] a_ext;
   logic [31:0] pp [8];
   logic [31:0] s;
   logic [31:0] c;
   logic [31:0] t;

   // Booth radix-4 recoding: one signed partial product per pair of multiplier bits
   always_comb begin
      b_ext = {b, 1'b0};
      a_ext = {{16{a[15]}}, a};
      for (int i = 0; i < 8; i++) begin
         case (b_ext[2*i +: 3])
            3'b001, 3'b010: pp[i] = a_ext;
            3'b011:         pp[i] = a_ext << 1;
            3'b100:         pp[i] = -(a_ext << 1);
            3'b101, 3'b110: pp[i] = -a_ext;
            default:        pp[i] = '0;
         endcase
         pp[i] = pp[i] << (2 * i);
      end
   end

   // 3:2 compressor chain keeps sum/carry apart; one carry-propagate add at the end
   always_comb begin
      s = '0;
      c = '0;
      t = '0;
      for (int i = 0; i < 8; i++) begin
         t = s ^ c ^ pp[i];
         c = ((s & c) | (s & pp[i]) | (c & pp[i])) << 1;
         s = t;
      end
      p = s + c;
   end

endmodule

// File: rtl/mult16_share_ctrl.sv
// rtl/mult16_share_ctrl.sv - round-robin sharing of one 16x16 signed multiplier between two requesters
module mult16_share_ctrl
   import mult16_share_pkg::*;
#(
   parameter int W = mult16_share_pkg::W
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic              req0_valid,
   input  logic [W-1:0]      req0_a,
   input  logic [W-1:0]      req0_b,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [W-1:0]      req1_a,
   input  logic [W-1:0]      req1_b,
   output logic              req1_ready,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [2*W-1:0]    res_p,
   output logic [ID_W-1:0]   res_id,
   output logic              busy
);

   state_t            state;
   state_t            state_nxt;
   logic [ID_W-1:0]   last;
   logic [W-1:0]      op_a;
   logic [W-1:0]      op_b;
   logic [ID_W-1:0]   op_id;
   logic              gnt_any;
   logic [ID_W-1:0]   gnt_id;
   logic              hs;
   logic [2*W-1:0]    mult_p;

   // Grant: a lone requester wins; under contention the one not served last wins
   always_comb begin
      gnt_any = req0_valid | req1_valid;
      if (req0_valid && req1_valid)
         gnt_id = ~last;
      else if (req1_valid)
         gnt_id = 1'b1;
      else
         gnt_id = 1'b0;
   end

   // State register
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   // Next state: accept, one settle cycle for the multiplier, then hold until consumed
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (hs) state_nxt = ST_MUL;
         ST_MUL:  state_nxt = ST_DONE;
         ST_DONE: if (res_ready) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Outputs: ready only in IDLE and never while reset is asserted
   always_comb begin
      req0_ready = (state == ST_IDLE) && !sys_rst && gnt_any && (gnt_id == 1'b0);
      req1_ready = (state == ST_IDLE) && !sys_rst && gnt_any && (gnt_id == 1'b1);
      hs         = req0_ready | req1_ready;
      busy       = (state != ST_IDLE);
   end

   // Operand capture, round-robin pointer and registered result
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         op_a      <= '0;
         op_b      <= '0;
         op_id     <= '0;
         last      <= 1'b1;
         res_p     <= '0;
         res_id    <= '0;
         res_valid <= 1'b0;
      end else begin
         if (hs) begin
            op_a  <= (gnt_id == 1'b1) ? req1_a : req0_a;
            op_b  <= (gnt_id == 1'b1) ? req1_b : req0_b;
            op_id <= gnt_id;
            last  <= gnt_id;
         end
         if (state == ST_MUL) begin
            res_p     <= mult_p;
            res_id    <= op_id;
            res_valid <= 1'b1;
         end else if ((state == ST_DONE) && res_ready) begin
            res_valid <= 1'b0;
         end
      end
   end

   booth4_wallace_mult16 u_mult (
      .a (op_a),
      .b (op_b),
      .p (mult_p)
   );

endmodule

// File: tb/tb_mult16_share_ctrl.sv
// tb/tb_mult16_share_ctrl.sv - directed vector bench for mult16_share_ctrl
module tb_mult16_share_ctrl;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [31:0] p;
   } vec_t;

   logic        sys_clk;
   logic        sys_rst;
   logic        req0_valid;
   logic [15:0] req0_a;
   logic [15:0] req0_b;
   logic        req0_ready;
   logic        req1_valid;
   logic [15:0] req1_a;
   logic [15:0] req1_b;
   logic        req1_ready;
   logic        res_valid;
   logic        res_ready;
   logic [31:0] res_p;
   logic [0:0]  res_id;
   logic        busy;

   int n_cmp = 0;
   int n_bad = 0;

   vec_t vecs [12];

   mult16_share_ctrl dut (
      .sys_clk    (sys_clk),
      .sys_rst    (sys_rst),
      .req0_valid (req0_valid),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .req1_ready (req1_ready),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_p      (res_p),
      .res_id     (res_id),
      .busy       (busy)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic set_req(input logic v0, input logic [15:0] a0, input logic [15:0] b0,
                          input logic v1, input logic [15:0] a1, input logic [15:0] b1);
      req0_valid = v0; req0_a = a0; req0_b = b0;
      req1_valid = v1; req1_a = a1; req1_b = b1;
   endtask

   task automatic next_cyc();
      @(posedge sys_clk);
      @(negedge sys_clk);
      #1;
   endtask

   // Entered shortly after a falling edge with the controller idle.
   task automatic run_op(input int id, input logic [15:0] a, input logic [15:0] b, input logic [31:0] exp);
      if (id == 0) set_req(1'b1, a, b, 1'b0, 16'h0, 16'h0);
      else         set_req(1'b0, 16'h0, 16'h0, 1'b1, a, b);
      #1;
      chk($sformatf("ready_own id%0d", id), (id == 0) ? req0_ready : req1_ready, 1);
      chk($sformatf("ready_other id%0d", id), (id == 0) ? req1_ready : req0_ready, 0);
      @(posedge sys_clk);
      @(negedge sys_clk);
      set_req(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0);
      #1;
      chk("mul res_valid", res_valid, 0);
      chk("mul busy", busy, 1);
      next_cyc();
      chk("done res_valid", res_valid, 1);
      chk($sformatf("res_p %h*%h", a, b), res_p, exp);
      chk("res_id", res_id, id);
      next_cyc();
      chk("after hs res_valid", res_valid, 0);
      chk("after hs busy", busy, 0);
   endtask

   initial begin
      logic [31:0] exp_p [4];
      logic        exp_id [4];
      int          got;

      vecs[0]  = '{16'd3,    16'hFFFB, 32'hFFFF_FFF1};
      vecs[1]  = '{16'd7,    16'd9,    32'h0000_003F};
      vecs[2]  = '{16'hFFFE, 16'd100,  32'hFFFF_FF38};
      vecs[3]  = '{16'h8000, 16'h8000, 32'h4000_0000};
      vecs[4]  = '{16'h8000, 16'h7FFF, 32'hC000_8000};
      vecs[5]  = '{16'h0000, 16'hFFFF, 32'h0000_0000};
      vecs[6]  = '{16'h7FFF, 16'h7FFF, 32'h3FFF_0001};
      vecs[7]  = '{16'hFFFF, 16'hFFFF, 32'h0000_0001};
      vecs[8]  = '{16'h04D2, 16'hFDC9, 32'hFFF5_52E2};
      vecs[9]  = '{16'h8000, 16'h0001, 32'hFFFF_8000};
      vecs[10] = '{16'h0100, 16'h0100, 32'h0001_0000};
      vecs[11] = '{16'h7FFF, 16'h8000, 32'hC000_8000};

      exp_p[0] = 32'h0000_003F; exp_id[0] = 1'b0;
      exp_p[1] = 32'hFFFF_FF38; exp_id[1] = 1'b1;
      exp_p[2] = 32'h0000_003F; exp_id[2] = 1'b0;
      exp_p[3] = 32'hFFFF_FF38; exp_id[3] = 1'b1;

      // Reset state, with both requesters asserting valid
      sys_rst   = 1'b1;
      res_ready = 1'b0;
      set_req(1'b1, 16'd1, 16'd2, 1'b1, 16'd3, 16'd4);
      #1;
      chk("rst res_valid", res_valid, 0);
      chk("rst res_p", res_p, 0);
      chk("rst res_id", res_id, 0);
      chk("rst busy", busy, 0);
      chk("rst req0_ready", req0_ready, 0);
      chk("rst req1_ready", req1_ready, 0);
      next_cyc();
      chk("rst hold req0_ready", req0_ready, 0);
      sys_rst   = 1'b0;
      res_ready = 1'b1;
      set_req(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0);
      #1;

      // Vector table, alternating requesters; ends on requester 1
      for (int i = 0; i < 12; i++)
         run_op(i % 2, vecs[i].a, vecs[i].b, vecs[i].p);

      // Contention: both valid every cycle, strict alternation starting with 0
      set_req(1'b1, 16'd7, 16'd9, 1'b1, 16'hFFFE, 16'd100);
      got = 0;
      for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
         next_cyc();
         if (res_valid) begin
            chk($sformatf("cont id #%0d", got), res_id, exp_id[got]);
            chk($sformatf("cont p #%0d", got), res_p, exp_p[got]);
            got++;
            if (got == 4) set_req(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0);
         end
      end
      chk("cont result count", got, 4);
      next_cyc();
      chk("cont idle busy", busy, 0);

      // Backpressure: result held for 5 cycles, no new grant meanwhile
      res_ready = 1'b0;
      set_req(1'b0, 16'h0, 16'h0, 1'b1, 16'd100, 16'hFFFD);
      #1;
      chk("bp req1_ready", req1_ready, 1);
      @(posedge sys_clk);
      @(negedge sys_clk);
      set_req(1'b1, 16'd1, 16'd1, 1'b1, 16'd2, 16'd2);
      next_cyc();
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("bp res_valid c%0d", k), res_valid, 1);
         chk($sformatf("bp res_p c%0d", k), res_p, 32'hFFFF_FED4);
         chk($sformatf("bp res_id c%0d", k), res_id, 1);
         chk($sformatf("bp req0_ready c%0d", k), req0_ready, 0);
         chk($sformatf("bp req1_ready c%0d", k), req1_ready, 0);
         next_cyc();
      end
      set_req(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0);
      res_ready = 1'b1;
      #1;
      chk("bp pre-hs res_valid", res_valid, 1);
      next_cyc();
      chk("bp post-hs res_valid", res_valid, 0);
      chk("bp post-hs busy", busy, 0);

      // Reset while in MUL: operation discarded, pointer back to 1
      set_req(1'b1, 16'd5, 16'd5, 1'b0, 16'h0, 16'h0);
      #1;
      chk("rm req0_ready", req0_ready, 1);
      @(posedge sys_clk);
      @(negedge sys_clk);
      set_req(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0);
      #1;
      chk("rm in MUL busy", busy, 1);
      sys_rst = 1'b1;
      set_req(1'b1, 16'd5, 16'd5, 1'b1, 16'd6, 16'd6);
      #1;
      chk("rm res_valid", res_valid, 0);
      chk("rm busy", busy, 0);
      chk("rm res_p", res_p, 0);
      chk("rm req0_ready", req0_ready, 0);
      chk("rm req1_ready", req1_ready, 0);
      next_cyc();
      chk("rm held res_valid", res_valid, 0);
      sys_rst = 1'b0;
      #1;
      chk("rm grant req0_ready", req0_ready, 1);
      chk("rm grant req1_ready", req1_ready, 0);
      @(posedge sys_clk);
      @(negedge sys_clk);
      set_req(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0);
      next_cyc();
      chk("rm result res_valid", res_valid, 1);
      chk("rm result res_id", res_id, 0);
      chk("rm result res_p", res_p, 32'd25);
      next_cyc();
      chk("rm final busy", busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
